// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: FSM states, opcode/funct
// values, datapath select encodings and the latched instruction class.
package mc_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [1:0] PCSRC_PC4 = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_GPR = 2'b11;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [2:0] ALUOP_ADD = 3'b000;
  localparam logic [2:0] ALUOP_SUB = 3'b001;
  localparam logic [2:0] ALUOP_OR  = 3'b010;
  localparam logic [2:0] ALUOP_LUI = 3'b011;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;

  // Write-back mux select, shared with the datapath.
  localparam logic [1:0] WB_AO  = 2'b00;
  localparam logic [1:0] WB_MD  = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [3:0] {
    R_ADDU, R_SUBU, R_JR, ORI, LUI, LW, SW, BEQ, J, JAL, NOP
  } cls_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: opcode/funct to cls; anything
// outside the supported set decodes as NOP.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls
);

  always_comb begin
    cls = NOP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = R_ADDU;
          FN_SUBU: cls = R_SUBU;
          FN_JR:   cls = R_JR;
          default: cls = NOP;
        endcase
      end
      OP_ORI:  cls = ORI;
      OP_LUI:  cls = LUI;
      OP_LW:   cls = LW;
      OP_SW:   cls = SW;
      OP_BEQ:  cls = BEQ;
      OP_J:    cls = J;
      OP_JAL:  cls = JAL;
      default: cls = NOP;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with Moore outputs.
// Define MC_CTRL_PERF_EN to add cycle and retired-instruction counters.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        PCWr,
  output logic [1:0]  PCSrc,
  output logic        IRWr,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic [1:0]  ExtOp,
  output logic        MemWr,
  output logic [1:0]  MemtoReg,
  output logic [4:0]  ra_idx,
  output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] inst_cnt
`endif
);

  logic [2:0] r_state;
  logic [2:0] w_next_state;
  cls_t       r_cls;
  cls_t       w_dec_cls;
  cls_t       w_cls;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .cls    (w_dec_cls)
  );

  // IR is only valid from DECODE on, so DECODE acts on the live decode and
  // every later state on the copy captured at the DECODE edge.
  assign w_cls = (r_state == ST_DECODE) ? w_dec_cls : r_cls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_cls   <= NOP;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_DECODE)
        r_cls <= w_dec_cls;
    end
  end

  always_comb begin
    w_next_state = ST_FETCH;
    case (r_state)
      ST_FETCH:  w_next_state = ST_DECODE;
      ST_DECODE: begin
        case (w_cls)
          J, R_JR, NOP: w_next_state = ST_FETCH;
          JAL:          w_next_state = ST_WB;
          default:      w_next_state = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        case (w_cls)
          R_ADDU, R_SUBU, ORI, LUI: w_next_state = ST_WB;
          LW, SW:                   w_next_state = ST_MEM;
          default:                  w_next_state = ST_FETCH;
        endcase
      end
      ST_MEM:  w_next_state = (w_cls == LW) ? ST_WB : ST_FETCH;
      default: w_next_state = ST_FETCH;
    endcase
  end

  // Reset gates every output so FETCH's enables cannot leak while reset is held.
  always_comb begin
    PCWr     = 1'b0;
    PCSrc    = PCSRC_PC4;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    RegDst   = REGDST_RT;
    ALUSrc   = 1'b0;
    ALUOp    = ALUOP_ADD;
    ExtOp    = EXT_ZERO;
    MemWr    = 1'b0;
    MemtoReg = WB_AO;
    if (!reset) begin
      case (r_state)
        ST_FETCH: begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
        ST_DECODE: begin
          if (w_cls == J) begin
            PCWr  = 1'b1;
            PCSrc = PCSRC_JMP;
          end else if (w_cls == R_JR) begin
            PCWr  = 1'b1;
            PCSrc = PCSRC_GPR;
          end
        end
        ST_EXEC: begin
          case (w_cls)
            R_SUBU: ALUOp = ALUOP_SUB;
            ORI: begin
              ALUSrc = 1'b1;
              ALUOp  = ALUOP_OR;
            end
            LUI: begin
              ALUSrc = 1'b1;
              ALUOp  = ALUOP_LUI;
            end
            LW, SW: begin
              ALUSrc = 1'b1;
              ExtOp  = EXT_SIGN;
            end
            BEQ: begin
              ALUOp = ALUOP_SUB;
              PCWr  = zero;
              PCSrc = PCSRC_BR;
            end
            default: ALUOp = ALUOP_ADD;
          endcase
        end
        ST_MEM:  MemWr = (w_cls == SW);
        ST_WB: begin
          case (w_cls)
            R_ADDU, R_SUBU: begin
              RegWr  = 1'b1;
              RegDst = REGDST_RD;
            end
            ORI, LUI: RegWr = 1'b1;
            LW: begin
              RegWr    = 1'b1;
              MemtoReg = WB_MD;
            end
            JAL: begin
              RegWr    = 1'b1;
              RegDst   = REGDST_RA;
              MemtoReg = WB_PC4;
              PCWr     = 1'b1;
              PCSrc    = PCSRC_JMP;
            end
            default: RegWr = 1'b0;
          endcase
        end
        default: PCWr = 1'b0;
      endcase
    end
  end

  assign ra_idx = RA_IDX;
  assign state  = r_state;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_inst_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cyc_cnt  <= 32'd0;
      r_inst_cnt <= 32'd0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_next_state == ST_FETCH && r_state != ST_FETCH)
        r_inst_cnt <= r_inst_cnt + 32'd1;
    end
  end

  assign cyc_cnt  = r_cyc_cnt;
  assign inst_cnt = r_inst_cnt;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-instruction cycle expectations are queued by
// the stimulus process and compared cycle by cycle by an independent monitor.
module tb_mc_ctrl;

  typedef logic [18:0] vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        PCWr, IRWr, RegWr, ALUSrc, MemWr;
  logic [1:0]  PCSrc, RegDst, ExtOp, MemtoReg;
  logic [2:0]  ALUOp;
  logic [4:0]  ra_idx;
  logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cyc_cnt, inst_cnt;
`endif

  mc_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .opcode   (opcode),
    .funct    (funct),
    .zero     (zero),
    .PCWr     (PCWr),
    .PCSrc    (PCSrc),
    .IRWr     (IRWr),
    .RegWr    (RegWr),
    .RegDst   (RegDst),
    .ALUSrc   (ALUSrc),
    .ALUOp    (ALUOp),
    .ExtOp    (ExtOp),
    .MemWr    (MemWr),
    .MemtoReg (MemtoReg),
    .ra_idx   (ra_idx),
    .state    (state)
`ifdef MC_CTRL_PERF_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .inst_cnt (inst_cnt)
`endif
  );

  always #5 clk = ~clk;

  vec_t dut_vec;
  assign dut_vec = {state, PCWr, PCSrc, IRWr, RegWr, RegDst, ALUSrc, ALUOp, ExtOp, MemWr, MemtoReg};

  vec_t  exp_q[$];
  int    n_vec  = 0;
  int    n_err  = 0;
  bit    mon_en = 1'b0;
  string names[11] = '{"addu", "subu", "jr", "ori", "lui", "lw", "sw", "beq", "j", "jal", "nop"};

  function automatic vec_t mk(int st, int pcwr, int pcsrc, int irwr, int regwr, int regdst,
                              int alusrc, int aluop, int extop, int memwr, int m2r);
    vec_t v;
    v = {st[2:0], pcwr[0], pcsrc[1:0], irwr[0], regwr[0], regdst[1:0], alusrc[0],
         aluop[2:0], extop[1:0], memwr[0], m2r[1:0]};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle behaviour of each instruction, written straight from the ISA table.
  task automatic push_instr(input int ins, input bit z, output int n);
    vec_t fetch_v, dec_v;
    fetch_v = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    dec_v   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(fetch_v);
    case (ins)
      0, 1: begin
        exp_q.push_back(dec_v);
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 0, (ins == 1) ? 1 : 0, 0, 0, 0));
        exp_q.push_back(mk(4, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
        n = 4;
      end
      2: begin exp_q.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0)); n = 2; end
      3, 4: begin
        exp_q.push_back(dec_v);
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 1, (ins == 3) ? 2 : 3, 0, 0, 0));
        exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        n = 4;
      end
      5: begin
        exp_q.push_back(dec_v);
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        n = 5;
      end
      6: begin
        exp_q.push_back(dec_v);
        exp_q.push_back(mk(2, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        exp_q.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        n = 4;
      end
      7: begin
        exp_q.push_back(dec_v);
        exp_q.push_back(mk(2, z ? 1 : 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        n = 3;
      end
      8: begin exp_q.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0)); n = 2; end
      9: begin
        exp_q.push_back(dec_v);
        exp_q.push_back(mk(4, 1, 2, 0, 1, 2, 0, 0, 0, 0, 2));
        n = 3;
      end
      default: begin exp_q.push_back(dec_v); n = 2; end
    endcase
  endtask

  task automatic encode(input int ins, output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] ops[10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
    logic [5:0] fns[3]  = '{6'h21, 6'h23, 6'h08};
    fn = 6'($urandom);
    if (ins < 10) begin
      op = ops[ins];
      if (ins < 3) fn = fns[ins];
    end else if ($urandom_range(0, 1) == 0) begin
      op = 6'h00;
      while (fn == 6'h21 || fn == 6'h23 || fn == 6'h08) fn = 6'($urandom);
    end else begin
      op = 6'($urandom);
      while (op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h04 || op == 6'h0D ||
             op == 6'h0F || op == 6'h23 || op == 6'h2B) op = 6'($urandom);
    end
  endtask

  always @(negedge clk) begin
    vec_t e;
    if (mon_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL cycle_vec: got st=%0d vec=%05h expected nothing queued", state, dut_vec);
      end else begin
        e = exp_q.pop_front();
        if (dut_vec !== e) begin
          n_err++;
          $display("FAIL cycle_vec: got st=%0d vec=%05h expected st=%0d vec=%05h",
                   state, dut_vec, e[18:16], e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    int dir_ins[10] = '{0, 3, 6, 8, 5, 9, 7, 7, 6, 10};
    bit dir_z[10]   = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [5:0] op, fn;
    int ins, n, total_cyc, n_ins;
    bit z;
    vec_t fetch_v;
    fetch_v = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    total_cyc = 0;
    n_ins = 0;

    reset = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'(dut_vec), 32'd0);
    check("ra_idx", 32'(ra_idx), 32'd31);

    // addu interrupted by reset in EXEC
    @(posedge clk); #1;
    reset = 1'b0; opcode = 6'h00; funct = 6'h21;
    #1 check("fetch_after_release", 32'(dut_vec), 32'(fetch_v));
    @(posedge clk); #1;
    check("addu_decode_state", 32'(state), 32'd1);
    @(posedge clk); #1;
    check("addu_exec_state", 32'(state), 32'd2);
    reset = 1'b1;
    #1 check("reset_mid_exec", 32'(dut_vec), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("regwr_held_in_reset", 32'({state, RegWr}), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1 check("fetch_after_rereset", 32'(dut_vec), 32'(fetch_v));
`ifdef MC_CTRL_PERF_EN
    check("cyc_cnt_reset", cyc_cnt, 32'd0);
    check("inst_cnt_reset", inst_cnt, 32'd0);
`endif

    mon_en = 1'b1;
    for (int i = 0; i < 210; i++) begin
      ins = (i < 10) ? dir_ins[i] : int'($urandom_range(0, 10));
      z   = (i < 10) ? dir_z[i] : 1'($urandom_range(0, 1));
      encode(ins, op, fn);
      opcode = op; funct = fn; zero = z;
      push_instr(ins, z, n);
      $display("instr %0d: %s op=%02h fn=%02h zero=%0d cycles=%0d", i, names[ins], op, fn, z, n);
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
        if (k >= 1) begin
          opcode = 6'($urandom);
          funct  = 6'($urandom);
        end
      end
      total_cyc += n;
      n_ins++;
`ifdef MC_CTRL_PERF_EN
      if (i == 3) begin
        check("cyc_cnt_4instr", cyc_cnt, 32'd14);
        check("inst_cnt_4instr", inst_cnt, 32'd4);
      end
`endif
    end
    mon_en = 1'b0;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef MC_CTRL_PERF_EN
    check("cyc_cnt_total", cyc_cnt, 32'(total_cyc));
    check("inst_cnt_total", inst_cnt, 32'(n_ins));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
